alu_share_arbiter: RTL

//  Shares one combinational ALU instance between two requesters (req 0: EX stage,
//  req 1: address/branch helper). Round-robin arbitration; grants one operation
//  per cycle and captures the ALU result in a register. Each requester has a

---
 rtl/alu_share_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between two
// requesters and keeps the registered result until its owner accepts it.
module alu_share_arbiter #(
   parameter int W      = 32,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*W-1:0]      req_opr1,
   input  logic [2*W-1:0]      req_opr2,
   input  logic [2*CTRL_W-1:0] req_ctrl,
   output logic [1:0]          rsp_valid,
   input  logic [1:0]          rsp_ready,
   output logic [W-1:0]        rsp_data,
   output logic                rsp_zero,
   output logic [W-1:0]        alu_opr1,
   output logic [W-1:0]        alu_opr2,
   output logic [CTRL_W-1:0]   alu_ctrl,
   input  logic [W-1:0]        alu_out,
   input  logic                alu_zero,
   output logic [CNT_W-1:0]    conflict_cnt,
   output logic [2:0]          dbg_state
);

   // Handshake: a transfer on any channel bit i happens in the cycle where
   // valid[i] and ready[i] are both high at the rising edge; a producer keeps
   // its payload stable while valid is high and ready is low.

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [W-1:0]      rsp_data_q, rsp_data_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              slot_free;
   logic              winner;
   logic              grant;
   logic [1:0]        waiting;
   logic [1:0]        wait_num;
   logic [CNT_W:0]    cnt_sum;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // The slot frees up in the same cycle the owner accepts, giving 1 op/cycle.
   always_comb begin
      slot_free = (state_q == IDLE) || rsp_ready[owner_q];
      winner    = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
      grant     = slot_free && (req_valid != 2'b00);
   end

   always_comb begin
      req_ready = 2'b00;
      alu_opr1  = '0;
      alu_opr2  = '0;
      alu_ctrl  = '0;
      if (grant) begin
         req_ready = winner ? 2'b10 : 2'b01;
         alu_opr1  = winner ? req_opr1[2*W-1:W] : req_opr1[W-1:0];
         alu_opr2  = winner ? req_opr2[2*W-1:W] : req_opr2[W-1:0];
         alu_ctrl  = winner ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      rsp_data_d = rsp_data_q;
      rsp_zero_d = rsp_zero_q;
      if (grant) begin
         state_d    = HOLD;
         owner_d    = winner;
         rr_ptr_d   = ~winner;
         rsp_data_d = alu_out;
         rsp_zero_d = alu_zero;
      end else if (slot_free) begin
         state_d = IDLE;
      end
   end

   // Saturating add of the number of requesters left waiting this cycle.
   always_comb begin
      waiting  = req_valid & ~req_ready;
      wait_num = {1'b0, waiting[0]} + {1'b0, waiting[1]};
      cnt_sum  = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, wait_num};
      cnt_d    = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         rr_ptr_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      rsp_valid    = (state_q == HOLD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      rsp_data     = rsp_data_q;
      rsp_zero     = rsp_zero_q;
      conflict_cnt = cnt_q;
      dbg_state    = {owner_q, rr_ptr_q, state_q == HOLD};
   end

endmodule
